// File: rtl/ntt_unload.sv
// ntt_unload
//   Drains an N-entry coefficient memory in address order once the upstream
//   NTT has finished. Each coefficient is reduced to canonical form [0, Q)
//   and streamed out over a valid/ready handshake.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse, accepted only while busy=0
//   en_r, addr_r      memory read request (shared read port)
//   data_r            read data, valid the cycle after en_r
//   data_out          canonical coefficient, driven from the FIFO head register
//   valid_out         data_out holds a coefficient
//   ready_out         consumer accepts data_out
//   busy              unload in progress
//   done_out          one-cycle pulse after the final handshake
//   range_err         sticky: some read value was >= 4Q; cleared by accepted start
//
// Handshake: a coefficient transfers in every cycle where valid_out and
// ready_out are both 1. While valid_out=1 and ready_out=0, data_out holds.
module ntt_unload #(
    parameter int Q  = 3329,
    parameter int N  = 256,
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          en_r,
    output logic [AW-1:0] addr_r,
    input  logic [DW-1:0] data_r,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    input  logic          ready_out,
    output logic          busy,
    output logic          done_out,
    output logic          range_err
);

    localparam int CW = AW + 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_issued;
    logic [CW-1:0] r_popped;
    logic          r_inflight;
    logic [1:0]    r_count;
    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic          r_done;
    logic          r_range_err;

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [2:0]    w_occ;
    logic [DW-1:0] w_red1;
    logic [DW-1:0] w_red;
    logic          w_over;

    assign w_pop  = (r_count != 2'd0) && ready_out;
    assign w_push = r_inflight;

    // Credit: stored entries plus the read in flight, minus the entry leaving
    // this cycle, must leave room for the data this read will return.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_issue = (r_state == S_RUN) && (r_issued < CW'(N))
                     && ((w_occ - {2'b00, w_pop}) < 3'd2);

    // Two conditional subtractions reach [0, Q) for any input below 4Q.
    assign w_over = (data_r >= DW'(4 * Q));
    assign w_red1 = (data_r >= DW'(2 * Q)) ? (data_r - DW'(2 * Q)) : data_r;
    assign w_red  = (w_red1 >= DW'(Q)) ? (w_red1 - DW'(Q)) : w_red1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_issued    <= '0;
            r_popped    <= '0;
            r_inflight  <= 1'b0;
            r_count     <= 2'd0;
            r_head      <= '0;
            r_tail      <= '0;
            r_done      <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;

            if (w_issue) r_issued <= r_issued + 1'b1;
            if (w_pop)   r_popped <= r_popped + 1'b1;
            if (w_push && w_over) r_range_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_issued    <= '0;
                        r_popped    <= '0;
                        r_range_err <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_pop && (r_popped == CW'(N - 1))) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Shift-style 2-entry FIFO: head feeds data_out, tail is the
            // second slot. Push into a full FIFO cannot occur (credit rule).
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= w_red;
                    else                 r_tail <= w_red;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) r_head <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= w_red;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_red;
                    end
                end
                default: ;
            endcase
        end
    end

    assign en_r      = w_issue;
    assign addr_r    = r_issued[AW-1:0];
    assign data_out  = r_head;
    assign valid_out = (r_count != 2'd0);
    assign busy      = (r_state == S_RUN);
    assign done_out  = r_done;
    assign range_err = r_range_err;

endmodule

// File: tb/tb_ntt_unload.sv
module tb_ntt_unload;
  localparam int Q  = 3329;
  localparam int N  = 256;
  localparam int DW = 16;
  localparam int AW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          ready_out = 1'b1;
  logic          en_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] data_r = '0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          busy;
  logic          done_out;
  logic          range_err;

  ntt_unload #(.Q(Q), .N(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .en_r      (en_r),
    .addr_r    (addr_r),
    .data_r    (data_r),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .busy      (busy),
    .done_out  (done_out),
    .range_err (range_err)
  );

  // memory model, read latency 1
  logic [DW-1:0] mem [N];
  always @(posedge clk) if (en_r) data_r <= mem[addr_r];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] golden(input logic [DW-1:0] x);
    if (int'(x) < 4 * Q) return DW'(int'(x) % Q);
    return DW'(int'(x) - 3 * Q);
  endfunction

  // scoreboard / protocol monitor
  logic [DW-1:0] exp_q[$];
  bit            mon_en = 0;
  int            rd_issued, hs_cnt;
  int            viol_order, viol_credit, viol_over, viol_stable;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            pop_i;

  always @(negedge clk) begin
    if (mon_en) begin
      pop_i = (valid_out && ready_out) ? 1 : 0;
      if (rd_issued - hs_cnt > 2) viol_over++;
      if (en_r) begin
        if (int'(addr_r) != rd_issued || rd_issued >= N) viol_order++;
        if (rd_issued - hs_cnt - pop_i >= 2) viol_credit++;
        rd_issued++;
      end
      if (prev_stall && (!valid_out || data_out !== prev_data)) viol_stable++;
      if (pop_i == 1) begin
        if (exp_q.size() == 0) check("extra_output", 1, 0);
        else check("data_out", data_out, exp_q.pop_front());
        hs_cnt++;
      end
      prev_stall = valid_out && !ready_out;
      prev_data  = data_out;
    end
  end

  // per-run observations
  int   first_v, done_c, en_hi, rise_c, rd5_c, snap_rd;
  logic c1_busy, c1_en, c1_rerr, snap_valid, rerr_at_done, busy_at_done, valid_at_done;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] snap_data;

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return (cyc > 20);
    return 1'b1;
  endfunction

  // Called at posedge+#1; that cycle is cycle 0 (start sampled at its end).
  task automatic run_unload(input string tag, input int mode, input int xstart_cyc,
                            input int abort_cyc);
    int cyc;
    int limit;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(golden(mem[i]));
    rd_issued = 0; hs_cnt = 0;
    viol_order = 0; viol_credit = 0; viol_over = 0; viol_stable = 0;
    first_v = -1; done_c = -1; en_hi = 0; rise_c = -1; rd5_c = -1; snap_rd = -1;
    prev_stall = 1'b0;
    mon_en = 1;
    limit = (abort_cyc > 0) ? abort_cyc + 10 : 3000;
    start = 1'b1;
    ready_out = ready_for(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    ready_out = ready_for(mode, cyc);
    while (cyc < limit && !(done_c >= 0 && abort_cyc == 0)) begin
      @(negedge clk);
      if (cyc == 1) begin
        c1_busy = busy; c1_en = en_r; c1_addr = addr_r; c1_rerr = range_err;
      end
      if (valid_out && first_v < 0) first_v = cyc;
      if (en_r && cyc <= N) en_hi++;
      if (en_r && addr_r == AW'(5) && rd5_c < 0) rd5_c = cyc;
      if (range_err && rise_c < 0) rise_c = cyc;
      if (done_out && done_c < 0) begin
        done_c = cyc; rerr_at_done = range_err;
        busy_at_done = busy; valid_at_done = valid_out;
      end
      if (cyc == 20) begin
        snap_rd = en_hi; snap_valid = valid_out; snap_data = data_out;
      end
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        check({tag, "_rst_en_r"}, en_r, 0);
        check({tag, "_rst_addr_r"}, addr_r, 0);
        check({tag, "_rst_data_out"}, data_out, 0);
        check({tag, "_rst_valid_out"}, valid_out, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_done_out"}, done_out, 0);
        check({tag, "_rst_range_err"}, range_err, 0);
      end
      @(posedge clk); #1;
      cyc++;
      rst = (cyc == abort_cyc);
      if (cyc == abort_cyc) mon_en = 0;
      start = (cyc == xstart_cyc);
      ready_out = ready_for(mode, cyc);
    end
    mon_en = 0;
    start = 1'b0;
    rst = 1'b0;
    if (abort_cyc == 0) begin
      check({tag, "_done_seen"}, (done_c >= 0), 1);
      check({tag, "_busy_at_done"}, busy_at_done, 0);
      check({tag, "_valid_at_done"}, valid_at_done, 0);
      check({tag, "_outputs_left"}, exp_q.size(), 0);
      check({tag, "_read_order"}, viol_order, 0);
      check({tag, "_credit"}, viol_credit, 0);
      check({tag, "_buffer_over_2"}, viol_over, 0);
      check({tag, "_stall_stable"}, viol_stable, 0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done_out, 0);
      check({tag, "_no_wrap_read"}, en_r, 0);
    end else begin
      check({tag, "_no_done_after_rst"}, (done_c < 0), 1);
    end
    ready_out = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_en_r", en_r, 0);
    check("reset_addr_r", addr_r, 0);
    check("reset_data_out", data_out, 0);
    check("reset_valid_out", valid_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done_out", done_out, 0);
    check("reset_range_err", range_err, 0);
    @(posedge clk); #1;

    // full-rate run, mem[i] = i, with an ignored start mid-run
    for (int i = 0; i < N; i++) mem[i] = DW'(i % Q);
    run_unload("t1", 0, 50, 0);
    check("t1_c1_busy", c1_busy, 1);
    check("t1_c1_en_r", c1_en, 1);
    check("t1_c1_addr_r", c1_addr, 0);
    check("t1_first_valid_cycle", first_v, 3);
    check("t1_done_cycle", done_c, 259);
    check("t1_en_r_cycles", en_hi, 256);

    // reduction boundaries
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    mem[0] = 16'd0;     mem[1] = 16'd3328;  mem[2] = 16'd3329;
    mem[3] = 16'd6657;  mem[4] = 16'd6658;  mem[5] = 16'd13315;
    check("t2_golden_4q_minus_1", golden(mem[5]), 3328);
    run_unload("t2", 0, 0, 0);
    check("t2_range_err", rerr_at_done, 0);

    // random data below 4Q, random backpressure
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 4 * Q - 1));
    run_unload("t3", 1, 0, 0);

    // consumer stalled for the first 20 cycles
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 4 * Q - 1));
    run_unload("t4", 2, 0, 0);
    check("t4_reads_while_stalled", snap_rd, 2);
    check("t4_valid_while_stalled", snap_valid, 1);
    check("t4_data_while_stalled", snap_data, golden(mem[0]));

    // out-of-range input, sticky flag kept across an ignored start
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    mem[5] = 16'hFFFF;
    check("t5_golden_ffff", golden(mem[5]), 55548);
    run_unload("t5", 0, 60, 0);
    check("t5_rise_after_read", (rd5_c > 0 && (rise_c == rd5_c + 1 || rise_c == rd5_c + 2)), 1);
    check("t5_range_err_at_done", rerr_at_done, 1);
    check("t5_range_err_after_done", range_err, 1);
    mem[5] = 16'd5;
    run_unload("t5b", 0, 0, 0);
    check("t5b_cleared_by_start", c1_rerr, 0);
    check("t5b_range_err_at_done", rerr_at_done, 0);

    // abort with reset at cycle 100, then a clean restart with a stray start
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 4 * Q - 1));
    run_unload("t6", 0, 0, 100);
    run_unload("t6r", 0, 50, 0);
    check("t6r_c1_addr_r", c1_addr, 0);
    check("t6r_done_cycle", done_c, 259);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end

endmodule
